cordic_rot_iter: RTL

CORDIC_ROT_ITER -- requirements
Module: cordic_rot_iter

---
 rtl/cordic_rot_iter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cordic_rot_iter.sv
// Iterative rotation-mode CORDIC: converts (r, angle in 0.01 deg) to (r*cos, r*sin),
// with one micro-rotation per clock on a single shared datapath and a ready/valid handshake.
module cordic_rot_iter #(
  parameter int N     = 16,
  parameter int STAGE = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] r_in,
  input  logic signed [N-1:0] angle_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] x_out,
  output logic signed [N-1:0] y_out,
  output logic                range_err
);

  localparam int W = N + 2;
  localparam logic signed [W-1:0] ZMAX = W'(9000);
  localparam logic signed [W-1:0] ZMIN = -ZMAX;
  localparam logic signed [W-1:0] SMAX = {3'b000, {(N-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {3'b111, {(N-1){1'b0}}};
  localparam logic [4:0]          LAST = 5'(STAGE - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic signed [W-1:0] x, y, z;
  logic [4:0]          i;
  logic                err_pend;

  logic signed [N+15:0] prod;
  logic signed [W-1:0]  x_init, a_ext, z_init;
  logic                 clamped;
  logic signed [W-1:0]  xs, ys, at;
  logic signed [W-1:0]  x_nxt, y_nxt, z_nxt;

  function automatic logic signed [W-1:0] atan_lut(input logic [4:0] k);
    case (k)
      5'd0:    atan_lut = W'(4500);
      5'd1:    atan_lut = W'(2656);
      5'd2:    atan_lut = W'(1403);
      5'd3:    atan_lut = W'(712);
      5'd4:    atan_lut = W'(357);
      5'd5:    atan_lut = W'(179);
      5'd6:    atan_lut = W'(89);
      5'd7:    atan_lut = W'(44);
      5'd8:    atan_lut = W'(22);
      5'd9:    atan_lut = W'(11);
      5'd10:   atan_lut = W'(5);
      5'd11:   atan_lut = W'(2);
      5'd12:   atan_lut = W'(1);
      default: atan_lut = '0;
    endcase
  endfunction

  function automatic logic signed [N-1:0] sat(input logic signed [W-1:0] v);
    if (v > SMAX)      sat = SMAX[N-1:0];
    else if (v < SMIN) sat = SMIN[N-1:0];
    else               sat = v[N-1:0];
  endfunction

  // Load path: gain pre-compensation (19898/2^15 ~ 1/1.64676) and angle clamping.
  always_comb begin
    prod    = $signed({{16{r_in[N-1]}}, r_in}) * (N+16)'(19898);
    x_init  = W'(prod >>> 15);
    a_ext   = W'(angle_in);
    clamped = 1'b0;
    z_init  = a_ext;
    if (a_ext > ZMAX) begin
      z_init  = ZMAX;
      clamped = 1'b1;
    end else if (a_ext < ZMIN) begin
      z_init  = ZMIN;
      clamped = 1'b1;
    end
  end

  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    at = atan_lut(i);
    if (!z[W-1]) begin
      x_nxt = x - ys;
      y_nxt = y + xs;
      z_nxt = z - at;
    end else begin
      x_nxt = x + ys;
      y_nxt = y - xs;
      z_nxt = z + at;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      range_err <= 1'b0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      i         <= '0;
      err_pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x        <= x_init;
            y        <= '0;
            z        <= z_init;
            i        <= '0;
            err_pend <= clamped;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          x <= x_nxt;
          y <= y_nxt;
          z <= z_nxt;
          i <= i + 5'd1;
          // Results are saturated from the final iteration's next-state values on the same edge.
          if (i == LAST) begin
            x_out     <= sat(x_nxt);
            y_out     <= sat(y_nxt);
            range_err <= err_pend;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
